// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are captured on grant, executed for one cycle, and returned on a held response channel.
module alu_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_opcode,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_opcode,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic [OP_WIDTH-1:0] alu_opcode,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_err
);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(5'b00001);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(5'b10001);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(5'b01001);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(5'b01101);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                last_grant;
  logic                grant;
  logic                take;
  logic                legal;
  logic [OP_WIDTH-1:0] cap_op;
  logic [WIDTH-1:0]    cap_a;
  logic [WIDTH-1:0]    cap_b;
  logic                cap_id;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // grant selection, request handshake and next state
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant = ~last_grant;
        end else begin
          grant = req1_valid;
        end
        if (!rst) begin
          req0_ready = req0_valid && !grant;
          req1_ready = req1_valid && grant;
        end
        if (req0_ready || req1_ready) begin
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign take = req0_ready || req1_ready;

  always_comb begin
    legal = 1'b0;
    case (cap_op)
      OP_ADD, OP_SUB, OP_XOR, OP_OR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // operand capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (take) begin
        last_grant <= grant;
        cap_id     <= grant;
        cap_op     <= grant ? req1_opcode : req0_opcode;
        cap_a      <= grant ? req1_a : req0_a;
        cap_b      <= grant ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cap_id;
        rsp_err   <= ~legal;
        rsp_data  <= legal ? alu_out : '0;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_opcode = cap_op;
  assign alu_a      = cap_a;
  assign alu_b      = cap_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter against a response scoreboard;
// the bench supplies the combinational ALU the arbiter drives.
module tb_alu_arbiter;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned OP_WIDTH = 5;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b10001;
  localparam logic [4:0] OP_XOR = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01101;
  localparam logic [4:0] OP_BAD = 5'b11111;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  rsp_t sb[$];
  logic id_log[$];
  rsp_t mon_exp, mon_got;
  int   total = 0;
  int   bad = 0;
  int   rsp_count = 0;
  int   base;
  logic acc0, acc1;

  alu_arbiter #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // external ALU; unsupported opcodes yield a nonzero junk value
  assign alu_out = (alu_opcode == OP_ADD) ? alu_a + alu_b :
                   (alu_opcode == OP_SUB) ? alu_a - alu_b :
                   (alu_opcode == OP_XOR) ? alu_a ^ alu_b :
                   (alu_opcode == OP_OR)  ? alu_a | alu_b : 32'hdeadbeef;

  function automatic rsp_t expect_rsp(input logic id, input logic [4:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (op)
      OP_ADD:  r.data = a + b;
      OP_SUB:  r.data = a - b;
      OP_XOR:  r.data = a ^ b;
      OP_OR:   r.data = a | b;
      default: begin r.data = 32'h0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic logic [4:0] pick_op();
    logic [4:0] ops [5];
    ops = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_BAD};
    return ops[$urandom_range(0, 4)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    total++;
    assert (sb.size() == 0 && !rsp_valid) else begin
      bad++;
      $error("FAIL drain observed=pending%0d expected=pending0", sb.size());
    end
  endtask

  // scoreboard: push on request handshake, pop and compare on response handshake
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (!(req0_ready && req1_ready)) else begin
        bad++;
        $error("FAIL dual_grant observed=both_ready expected=at_most_one");
      end
      if (req0_valid && req0_ready) sb.push_back(expect_rsp(1'b0, req0_opcode, req0_a, req0_b));
      if (req1_valid && req1_ready) sb.push_back(expect_rsp(1'b1, req1_opcode, req1_a, req1_b));
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        id_log.push_back(rsp_id);
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL rsp_unexpected observed=id%0d/%h expected=no_response", rsp_id, rsp_data);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          mon_got = {rsp_id, rsp_data, rsp_err};
          total++;
          assert (mon_got === mon_exp) else begin
            bad++;
            $error("FAIL rsp_payload observed=id%0d/%h/err%0d expected=id%0d/%h/err%0d",
                   mon_got.id, mon_got.data, mon_got.err, mon_exp.id, mon_exp.data, mon_exp.err);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);

    // valid during reset: no handshake
    req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 32'haa554422; req0_b = 32'h00993300;
    #1;
    check("rst_wins_ready0", 32'(req0_ready), 32'h0);
    tick();
    check("rst_no_capture", alu_a, 32'h0);

    // single ADD from req0, response held with rsp_ready low
    rst = 1'b0;
    #1;
    check("t1_ready0", 32'(req0_ready), 32'h1);
    check("t1_ready1", 32'(req1_ready), 32'h0);
    tick();
    req0_valid = 1'b0;
    check("t1_exec_alu_op", 32'(alu_opcode), 32'(OP_ADD));
    check("t1_exec_alu_a", alu_a, 32'haa554422);
    check("t1_exec_alu_b", alu_b, 32'h00993300);
    check("t1_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_id", 32'(rsp_id), 32'h0);
    check("t1_rsp_data", rsp_data, 32'haaee7722);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    rsp_ready = 1'b1;
    tick();
    check("t1_rsp_done", 32'(rsp_valid), 32'h0);

    // req1 SUB with rsp_ready tied high
    req1_valid = 1'b1; req1_opcode = OP_SUB; req1_a = 32'hff009867; req1_b = 32'h984487dd;
    #1;
    check("t2_ready1", 32'(req1_ready), 32'h1);
    check("t2_ready0", 32'(req0_ready), 32'h0);
    tick();
    req1_valid = 1'b0;
    check("t2_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t2_rsp_id", 32'(rsp_id), 32'h1);
    check("t2_rsp_data", rsp_data, 32'h66bc108a);
    tick();
    check("t2_rsp_one_cycle", 32'(rsp_valid), 32'h0);

    // continuous contention: strict alternation starting with req0
    req0_valid = 1'b1; req0_opcode = OP_XOR; req0_a = 32'h00ffdd88; req0_b = 32'hff009865;
    req1_valid = 1'b1; req1_opcode = OP_OR;  req1_a = 32'haadd9987; req1_b = 32'h0087ff78;
    #1;
    check("t3_idle_ready0", 32'(req0_ready), 32'h1);
    check("t3_idle_ready1", 32'(req1_ready), 32'h0);
    base = rsp_count;
    id_log.delete();
    for (int i = 0; i < 40 && rsp_count < base + 4; i++) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_rsp_count", 32'(rsp_count - base), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_id%0d", i), 32'((id_log.size() > i) ? id_log[i] : 1'bx), 32'(i % 2));
    end
    drain();

    // illegal opcode zeroes the data and flags the error
    req0_valid = 1'b1; req0_opcode = OP_BAD; req0_a = 32'h12345678; req0_b = 32'h9abcdef0;
    #1;
    check("t5_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t5_rsp_err", 32'(rsp_err), 32'h1);
    check("t5_rsp_data", rsp_data, 32'h0);
    drain();

    // back-pressure: response held stable, no new grants
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 32'h00ffdd88; req0_b = 32'hff009865;
    #1;
    check("t4_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_opcode = OP_XOR; req0_a = 32'h00ffdd88; req0_b = 32'hff009865;
    req1_valid = 1'b1; req1_opcode = OP_OR;  req1_a = 32'haadd9987; req1_b = 32'h0087ff78;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t4_hold_valid%0d", i), 32'(rsp_valid), 32'h1);
      check($sformatf("t4_hold_data%0d", i), rsp_data, 32'h000075ed);
      check($sformatf("t4_hold_id%0d", i), 32'(rsp_id), 32'h0);
      check($sformatf("t4_hold_ready0_%0d", i), 32'(req0_ready), 32'h0);
      check($sformatf("t4_hold_ready1_%0d", i), 32'(req1_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    tick();
    #1;
    check("t4_idle_ready1", 32'(req1_ready), 32'h1);
    tick();
    req1_valid = 1'b0;
    drain();

    // reset during EXEC drops the transaction
    req1_valid = 1'b1; req1_opcode = OP_ADD; req1_a = 32'h11111111; req1_b = 32'h22222222;
    #1;
    check("t6_ready1", 32'(req1_ready), 32'h1);
    tick();
    req1_valid = 1'b0;
    check("t6_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b1;
    tick();
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t6_rst_rsp_data", rsp_data, 32'h0);
    check("t6_rst_alu_a", alu_a, 32'h0);
    check("t6_rst_alu_op", 32'(alu_opcode), 32'h0);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_no_rsp%0d", i), 32'(rsp_valid), 32'h0);
    end
    req0_valid = 1'b1; req0_opcode = OP_SUB; req0_a = 32'h00000005; req0_b = 32'h00000007;
    req1_valid = 1'b1; req1_opcode = OP_XOR; req1_a = 32'h0f0f0f0f; req1_b = 32'hffffffff;
    #1;
    check("t6_after_rst_ready0", 32'(req0_ready), 32'h1);
    check("t6_after_rst_ready1", 32'(req1_ready), 32'h0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // random traffic with random back-pressure; valid held until accepted
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_opcode = pick_op();
        req0_a = $urandom; req0_b = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_opcode = pick_op();
        req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
